// File: rtl/stack_unit.sv
// Parametrised LIFO stack executing PUSH, PUSH_LINK, POP and POP_LINK requests.
// Rejected ops have no side effect beyond an error pulse and a sticky overflow/underflow flag.
module stack_unit #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] lr_in_i,
  input  logic              clr_err_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] lr_out_o,
  output logic              lr_we_o,
  output logic [CNT_W-1:0]  sp_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] SP_MAX = CNT_W'(DEPTH);
  localparam logic [1:0] OP_POP       = 2'b00;
  localparam logic [1:0] OP_POP_LINK  = 2'b01;
  localparam logic [1:0] OP_PUSH      = 2'b10;
  localparam logic [1:0] OP_PUSH_LINK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PL2   = 2'b01,
    ST_POPL2 = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic [DATA_W-1:0] mem_q [0:DEPTH-1];
  logic [CNT_W-1:0]  sp_q, sp_d;
  logic [DATA_W-1:0] lr_lat_q, lr_lat_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] lr_out_q, lr_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              lr_we_q, lr_we_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              full_q, empty_q;
  logic              we_s;
  logic [DATA_W-1:0] wdata_s;
  logic [CNT_W-1:0]  sp_m1_s;
  logic [DATA_W-1:0] top_s;
  logic              accept_s;

  assign ready_o  = (state_q == ST_IDLE) && !rst_i;
  assign accept_s = req_i && ready_o;
  assign sp_m1_s  = sp_q - CNT_W'(1);
  assign top_s    = mem_q[sp_m1_s[AW-1:0]];

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    lr_lat_d   = lr_lat_q;
    rd_data_d  = rd_data_q;
    lr_out_d   = lr_out_q;
    rd_valid_d = 1'b0;
    lr_we_d    = 1'b0;
    err_d      = 1'b0;
    // A coinciding rejection below overrides this clear.
    ovf_d      = ovf_q && !clr_err_i;
    unf_d      = unf_q && !clr_err_i;
    we_s       = 1'b0;
    wdata_s    = wr_data_i;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (op_i)
            OP_PUSH: begin
              if (sp_q < SP_MAX) begin
                we_s = 1'b1;
                sp_d = sp_q + CNT_W'(1);
              end else begin
                err_d = 1'b1;
                ovf_d = 1'b1;
              end
            end
            OP_PUSH_LINK: begin
              if (sp_q < SP_MAX - CNT_W'(1)) begin
                we_s     = 1'b1;
                sp_d     = sp_q + CNT_W'(1);
                lr_lat_d = lr_in_i;
                state_d  = ST_PL2;
              end else begin
                err_d = 1'b1;
                ovf_d = 1'b1;
              end
            end
            OP_POP: begin
              if (sp_q >= CNT_W'(1)) begin
                rd_data_d  = top_s;
                rd_valid_d = 1'b1;
                sp_d       = sp_m1_s;
              end else begin
                err_d = 1'b1;
                unf_d = 1'b1;
              end
            end
            OP_POP_LINK: begin
              if (sp_q >= CNT_W'(2)) begin
                lr_out_d = top_s;
                lr_we_d  = 1'b1;
                sp_d     = sp_m1_s;
                state_d  = ST_POPL2;
              end else begin
                err_d = 1'b1;
                unf_d = 1'b1;
              end
            end
            default: begin
              err_d = 1'b0;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PL2: begin
        we_s    = 1'b1;
        wdata_s = lr_lat_q;
        sp_d    = sp_q + CNT_W'(1);
        state_d = ST_IDLE;
      end
      ST_POPL2: begin
        rd_data_d  = top_s;
        rd_valid_d = 1'b1;
        sp_d       = sp_m1_s;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      sp_q       <= '0;
      lr_lat_q   <= '0;
      rd_data_q  <= '0;
      lr_out_q   <= '0;
      rd_valid_q <= 1'b0;
      lr_we_q    <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      lr_lat_q   <= lr_lat_d;
      rd_data_q  <= rd_data_d;
      lr_out_q   <= lr_out_d;
      rd_valid_q <= rd_valid_d;
      lr_we_q    <= lr_we_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      full_q     <= (sp_d == SP_MAX);
      empty_q    <= (sp_d == '0);
    end
  end

  // Storage is deliberately left unreset; only entries below Sp are meaningful.
  always_ff @(posedge clk_i) begin
    if (we_s && !rst_i) begin
      mem_q[sp_q[AW-1:0]] <= wdata_s;
    end
  end

  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign lr_out_o    = lr_out_q;
  assign lr_we_o     = lr_we_q;
  assign sp_o        = sp_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign err_o       = err_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: a queue-based LIFO model predicts pops, link writes and
// error pulses; a negedge monitor compares them whenever the DUT raises a pulse.
module tb_stack_unit;
  localparam int DW = 32;
  localparam int DP = 8;
  localparam int CW = $clog2(DP + 1);
  localparam logic [1:0] OP_POP       = 2'b00;
  localparam logic [1:0] OP_POP_LINK  = 2'b01;
  localparam logic [1:0] OP_PUSH      = 2'b10;
  localparam logic [1:0] OP_PUSH_LINK = 2'b11;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_i = 1'b0;
  logic [1:0]    op_i = 2'b00;
  logic [DW-1:0] wr_data_i = '0;
  logic [DW-1:0] lr_in_i = '0;
  logic          clr_err_i = 1'b0;
  logic          ready_o, rd_valid_o, lr_we_o, full_o, empty_o, err_o, overflow_o, underflow_o;
  logic [DW-1:0] rd_data_o, lr_out_o;
  logic [CW-1:0] sp_o;

  stack_unit #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .op_i(op_i), .wr_data_i(wr_data_i),
    .lr_in_i(lr_in_i), .clr_err_i(clr_err_i), .ready_o(ready_o), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .lr_out_o(lr_out_o), .lr_we_o(lr_we_o), .sp_o(sp_o),
    .full_o(full_o), .empty_o(empty_o), .err_o(err_o), .overflow_o(overflow_o),
    .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model[$];
  logic [DW-1:0] exp_rd[$];
  logic [DW-1:0] exp_lr[$];
  bit            exp_err[$];
  bit            ovf_m = 1'b0;
  bit            unf_m = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_i) begin
      if (rd_valid_o) begin
        if (exp_rd.size() == 0) chk("rd_valid_unexpected", rd_valid_o, 0);
        else chk("rd_data", rd_data_o, exp_rd.pop_front());
      end
      if (lr_we_o) begin
        if (exp_lr.size() == 0) chk("lr_we_unexpected", lr_we_o, 0);
        else chk("lr_out", lr_out_o, exp_lr.pop_front());
      end
      if (err_o) begin
        if (exp_err.size() == 0) chk("err_unexpected", err_o, 0);
        else chk("err_pulse", err_o, exp_err.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) chk("ready_timeout", ready_o, 1);
  endtask

  // Issue one op at a negedge; the model is updated at the accept point.
  task automatic do_op(input logic [1:0] op, input logic [DW-1:0] wd, input logic [DW-1:0] lr,
                       input bit clr);
    wait_ready();
    req_i = 1'b1; op_i = op; wr_data_i = wd; lr_in_i = lr; clr_err_i = clr;
    if (clr) begin ovf_m = 1'b0; unf_m = 1'b0; end
    case (op)
      OP_PUSH:
        if (model.size() < DP) model.push_back(wd);
        else begin exp_err.push_back(1'b1); ovf_m = 1'b1; end
      OP_PUSH_LINK:
        if (model.size() <= DP - 2) begin model.push_back(wd); model.push_back(lr); end
        else begin exp_err.push_back(1'b1); ovf_m = 1'b1; end
      OP_POP:
        if (model.size() >= 1) exp_rd.push_back(model.pop_back());
        else begin exp_err.push_back(1'b1); unf_m = 1'b1; end
      default:
        if (model.size() >= 2) begin
          exp_lr.push_back(model.pop_back());
          exp_rd.push_back(model.pop_back());
        end else begin exp_err.push_back(1'b1); unf_m = 1'b1; end
    endcase
    @(negedge clk);
    req_i = 1'b0; clr_err_i = 1'b0;
  endtask

  task automatic check_state(input string tag);
    wait_ready();
    chk({tag, "_sp"}, sp_o, model.size());
    chk({tag, "_full"}, full_o, model.size() == DP);
    chk({tag, "_empty"}, empty_o, model.size() == 0);
    chk({tag, "_ovf"}, overflow_o, ovf_m);
    chk({tag, "_unf"}, underflow_o, unf_m);
  endtask

  task automatic clear_flags();
    clr_err_i = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0;
    ovf_m = 1'b0; unf_m = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] op;
    int pct;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready_o, 0);
    chk("rst_sp", sp_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_lr_out", lr_out_o, 0);
    chk("rst_pulses", {rd_valid_o, lr_we_o, err_o, overflow_o, underflow_o}, 0);
    rst_i = 1'b0;
    #1 chk("rst_release_ready", ready_o, 1);
    @(negedge clk);

    do_op(OP_PUSH, 32'h1111, '0, 1'b0);
    do_op(OP_PUSH, 32'h2222, '0, 1'b0);
    check_state("push2");
    do_op(OP_POP, '0, '0, 1'b0);
    do_op(OP_POP, '0, '0, 1'b0);
    check_state("pop2");

    do_op(OP_PUSH_LINK, 32'hAAAA, 32'h0123, 1'b0);
    chk("pl_ready_low", ready_o, 0);
    @(negedge clk);
    chk("pl_ready_back", ready_o, 1);
    check_state("pushlink");
    do_op(OP_POP_LINK, '0, '0, 1'b0);
    check_state("poplink");

    for (int i = 0; i < DP; i++) do_op(OP_PUSH, $urandom(), '0, 1'b0);
    check_state("fill");
    do_op(OP_PUSH, 32'hDEAD_BEEF, '0, 1'b0);
    check_state("overflow");
    do_op(OP_PUSH_LINK, 32'h5555, 32'h6666, 1'b0);
    check_state("overflow_pl");
    clear_flags();
    check_state("clr_ovf");
    for (int i = 0; i < DP; i++) do_op(OP_POP, '0, '0, 1'b0);
    check_state("drain");

    do_op(OP_PUSH, 32'h0000_7777, '0, 1'b0);
    do_op(OP_POP_LINK, '0, '0, 1'b0);
    check_state("underflow_pl");
    do_op(OP_POP, '0, '0, 1'b0);
    check_state("single_pop");
    do_op(OP_POP, '0, '0, 1'b1);
    check_state("clr_vs_set");
    clear_flags();

    do_op(OP_PUSH, 32'h0000_0042, '0, 1'b0);
    do_op(OP_PUSH_LINK, 32'h0000_0BAD, 32'h0000_0CAD, 1'b0);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    model.delete(); ovf_m = 1'b0; unf_m = 1'b0;
    #1;
    chk("midrst_ready", ready_o, 1);
    chk("midrst_sp", sp_o, 0);
    chk("midrst_pulses", {rd_valid_o, lr_we_o, err_o}, 0);
    @(negedge clk);
    check_state("after_midrst");

    for (int i = 0; i < 400; i++) begin
      pct = (i % 100 < 50) ? 65 : 35;
      if ($urandom_range(0, 99) < pct) op = ($urandom_range(0, 3) == 0) ? OP_PUSH_LINK : OP_PUSH;
      else op = ($urandom_range(0, 3) == 0) ? OP_POP_LINK : OP_POP;
      do_op(op, $urandom(), $urandom(), $urandom_range(0, 15) == 0);
      check_state("rand");
    end
    while (model.size() > 0) do_op(OP_POP, '0, '0, 1'b0);
    check_state("final");
    repeat (3) @(negedge clk);
    chk("leftover_rd", exp_rd.size(), 0);
    chk("leftover_lr", exp_lr.size(), 0);
    chk("leftover_err", exp_err.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
